// File: rtl/mxu_pkg.sv
// Shared constants and the result matrix type for the matrix multiplier,
// its result drain, and the benches.
package mxu_pkg;

    localparam int DIM          = 4;
    localparam int BITWIDTH     = 8;
    localparam int OUT_BITWIDTH = 18;

    typedef logic [DIM-1:0][DIM-1:0][OUT_BITWIDTH-1:0] matrix_y_t;

endpackage

// File: rtl/mxu_pingpong_buf.sv
// Two-slot matrix buffer: captures whole matrices on cap_valid and releases
// the oldest slot on free, keeping capture order.
module mxu_pingpong_buf #(
    parameter int DIM       = mxu_pkg::DIM,
    parameter int OUT_WIDTH = mxu_pkg::OUT_BITWIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cap_valid,
    input  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] cap_data,
    input  logic                                  free,
    output logic                                  cap_accept,
    output logic                                  cap_drop,
    output logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] rd_data,
    output logic [1:0]                            count,
    output logic                                  full
);

    typedef logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] mat_t;

    mat_t       slot_q [2];
    mat_t       slot_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       slot_free;

    // A slot being released this cycle may be refilled in the same cycle;
    // when both are busy wr_ptr equals rd_ptr, so the refill lands in the freed slot.
    always_comb begin
        slot_free  = (count_q != 2'd2) || free;
        cap_accept = cap_valid && slot_free;
        cap_drop   = cap_valid && !slot_free;
    end

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (cap_accept) begin
            slot_d[wr_ptr_q] = cap_data;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (free) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({cap_accept, free})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        rd_data = slot_q[rd_ptr_q];
        count   = count_q;
        full    = (count_q == 2'd2);
    end

endmodule

// File: rtl/mxu_result_drain.sv
// Receive side of the matrix multiplier result path: buffers finished
// matrices and streams their elements row-major over valid/ready.
module mxu_result_drain #(
    parameter int DIM       = mxu_pkg::DIM,
    parameter int OUT_WIDTH = mxu_pkg::OUT_BITWIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] y_in,
    input  logic                                  y_valid,
    output logic [OUT_WIDTH-1:0]                  elem_data,
    output logic [$clog2(DIM)-1:0]                elem_row,
    output logic [$clog2(DIM)-1:0]                elem_col,
    output logic                                  elem_last,
    output logic                                  elem_valid,
    input  logic                                  elem_ready,
    output logic                                  full,
    output logic                                  overflow,
    input  logic                                  clear_overflow,
    output logic [CNT_WIDTH-1:0]                  mat_count
);

    localparam int IW   = $clog2(DIM);
    localparam int NEL  = DIM * DIM;
    localparam int IDXW = $clog2(NEL);

    logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] rd_data;
    logic [1:0]           buf_count;
    logic                 cap_accept, cap_drop;
    logic                 xfer, at_last, free;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] mat_count_q, mat_count_d;

    mxu_pingpong_buf #(
        .DIM       (DIM),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_valid  (y_valid),
        .cap_data   (y_in),
        .free       (free),
        .cap_accept (cap_accept),
        .cap_drop   (cap_drop),
        .rd_data    (rd_data),
        .count      (buf_count),
        .full       (full)
    );

    always_comb begin
        elem_valid = (buf_count != 2'd0);
        at_last    = (idx_q == IDXW'(NEL - 1));
        xfer       = elem_valid && elem_ready;
        free       = xfer && at_last;
    end

    always_comb begin
        idx_d       = idx_q;
        mat_count_d = mat_count_q;
        overflow_d  = overflow_q;
        if (xfer) begin
            idx_d = at_last ? '0 : idx_q + IDXW'(1);
        end
        if (free) begin
            mat_count_d = mat_count_q + CNT_WIDTH'(1);
        end
        // A drop in the same cycle as a clear leaves the flag set.
        if (cap_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            mat_count_q <= '0;
        end else begin
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            mat_count_q <= mat_count_d;
        end
    end

    // Outputs select from stored slots only; y_in never reaches them directly.
    always_comb begin
        elem_row  = IW'(idx_q / IDXW'(DIM));
        elem_col  = IW'(idx_q % IDXW'(DIM));
        elem_data = rd_data[elem_row][elem_col];
        elem_last = at_last;
        overflow  = overflow_q;
        mat_count = mat_count_q;
    end

endmodule
